// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multicycle data-memory sequencer with read-modify-write for sub-word stores.
// Optional build macro MEM_ALIGN_CHK_EN rejects misaligned HALF/WORD accesses before any RAM cycle.
module mem_access_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [1:0]        i_type,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic [1:0]        o_pos,
  output logic [1:0]        o_type,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] MEM_WTYPE_WORD = 2'd0;
  localparam logic [1:0] MEM_WTYPE_HALF = 2'd1;
  localparam logic [1:0] MEM_WTYPE_BYTE = 2'd2;
  localparam logic [7:0] TO_LAST        = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    FIN   = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t      state_r, next_s;
  logic        we_r;
  logic [31:0] wdata_r;
  logic [31:0] merge_buf_r;
  logic [7:0]  cnt_r;
  logic        is_half_s, is_byte_s, is_word_s, misalign_s, rmw_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^{i_addr[31:ADDR_W+2]};

  // Replace one byte lane or halfword of the RAM word with the right-justified store data.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [1:0] ty, input logic [1:0] pos);
    logic [31:0] w;
    w = old_w;
    case (ty)
      MEM_WTYPE_HALF: begin
        if (pos[1]) w[31:16] = new_w[15:0];
        else        w[15:0]  = new_w[15:0];
      end
      MEM_WTYPE_BYTE: begin
        case (pos)
          2'd0:    w[7:0]   = new_w[7:0];
          2'd1:    w[15:8]  = new_w[7:0];
          2'd2:    w[23:16] = new_w[7:0];
          2'd3:    w[31:24] = new_w[7:0];
          default: w        = old_w;
        endcase
      end
      default: w = new_w;
    endcase
    return w;
  endfunction

  // Request decode: access width, alignment rejection and whether a store needs RMW.
  always_comb begin
    is_half_s  = (i_type == MEM_WTYPE_HALF);
    is_byte_s  = (i_type == MEM_WTYPE_BYTE);
    is_word_s  = !is_half_s && !is_byte_s;
`ifdef MEM_ALIGN_CHK_EN
    misalign_s = (is_half_s && i_addr[0]) || (is_word_s && (i_addr[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
`endif
    rmw_s      = is_byte_s || (is_half_s && !i_addr[0]);
  end

  // Next-state logic; an ack wins over a timeout landing in the same cycle.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_req) begin
          if (misalign_s)          next_s = ERR;
          else if (!i_we || rmw_s) next_s = RD;
          else                     next_s = WR;
        end else begin
          next_s = IDLE;
        end
      end
      RD, WR: begin
        if (mem_ack) begin
          if (state_r == RD && we_r) next_s = MERGE;
          else                       next_s = FIN;
        end else if (cnt_r == TO_LAST) begin
          next_s = ERR;
        end else begin
          next_s = state_r;
        end
      end
      MERGE:   next_s = WR;
      FIN:     next_s = IDLE;
      ERR:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_s;
  end

  // Registered outputs, request latch, timeout counter and data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= 32'd0;
      o_pos       <= 2'd0;
      o_type      <= 2'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
      we_r        <= 1'b0;
      wdata_r     <= 32'd0;
      merge_buf_r <= 32'd0;
      cnt_r       <= 8'd0;
    end else begin
      mem_req <= (next_s == RD) || (next_s == WR);
      mem_we  <= (next_s == WR);
      o_done  <= (next_s == FIN);
      o_err   <= (next_s == ERR);
      o_busy  <= (next_s != IDLE);

      if (state_r != next_s)       cnt_r <= 8'd0;
      else if (mem_req && !mem_ack) cnt_r <= cnt_r + 8'd1;
      else                          cnt_r <= cnt_r;

      if (state_r == IDLE && i_req) begin
        we_r      <= i_we;
        o_type    <= i_type;
        o_pos     <= i_addr[1:0];
        mem_addr  <= i_addr[ADDR_W+1:2];
        wdata_r   <= i_wdata;
        mem_wdata <= i_wdata;
      end

      if (state_r == RD && mem_ack) begin
        if (we_r) merge_buf_r <= mem_rdata;
        else      o_rdata     <= mem_rdata;
      end

      if (state_r == MERGE) mem_wdata <= merge_word(merge_buf_r, wdata_r, o_type, o_pos);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: RAM responder with programmable ack delay plus expectation queue.
module tb_mem_access_ctrl;

  localparam logic [1:0] WORD = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] BYTE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [1:0]  i_type = 2'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_rdata;
  logic [1:0]  o_pos, o_type;
  logic        mem_req, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  // RAM model controls and write log
  int          ack_delay = 0;
  logic        no_ack = 1'b0;
  logic [31:0] rd_word = 32'd0;
  int          req_age = 0;
  int          wr_cnt = 0;
  logic [10:0] last_wa = 11'd0;
  logic [31:0] last_wd = 32'd0;

  typedef struct {
    string       tag;
    int          lat;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  pos;
    logic [1:0]  ty;
    int          nwr;
    logic [10:0] addr;
    logic [31:0] wd;
    int          nreq;
  } exp_t;

  exp_t sb[$];

  mem_access_ctrl #(.ADDR_W(11), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_we(i_we), .i_type(i_type),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_rdata(o_rdata), .o_pos(o_pos), .o_type(o_type),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // RAM responder: acks in the (ack_delay+1)-th cycle of a request, driven off the falling edge.
  always @(negedge clk) begin
    if (mem_req && !mem_ack) begin
      if (!no_ack && req_age == ack_delay) begin
        mem_ack <= 1'b1;
        req_age <= 0;
        if (mem_we) begin
          wr_cnt  <= wr_cnt + 1;
          last_wa <= mem_addr;
          last_wd <= mem_wdata;
        end else begin
          mem_rdata <= rd_word;
        end
      end else begin
        mem_ack <= 1'b0;
        req_age <= req_age + 1;
      end
    end else begin
      mem_ack <= 1'b0;
      req_age <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int lat, input logic done, input logic err,
                      input logic [31:0] rdata, input logic [1:0] pos, input logic [1:0] ty,
                      input int nwr, input logic [10:0] addr, input logic [31:0] wd, input int nreq);
    exp_t e;
    e.tag = tag; e.lat = lat; e.done = done; e.err = err; e.rdata = rdata;
    e.pos = pos; e.ty = ty; e.nwr = nwr; e.addr = addr; e.wd = wd; e.nreq = nreq;
    sb.push_back(e);
  endtask

  // Issue one access, hold i_req until done/err, then compare against the queued expectation.
  task automatic run_access(input logic we, input logic [1:0] ty, input logic [31:0] addr,
                            input logic [31:0] wd);
    exp_t        e;
    int          base, lat, nreq, extra;
    logic        done, err, busy1;
    logic [10:0] raddr;
    @(negedge clk);
    i_req = 1'b1; i_we = we; i_type = ty; i_addr = addr; i_wdata = wd;
    base = wr_cnt;
    lat = 0; nreq = 0; done = 1'b0; err = 1'b0; busy1 = 1'b0; raddr = 11'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = o_busy;
      if (mem_req) begin
        if (nreq == 0) raddr = mem_addr;
        nreq++;
      end
      if (o_done || o_err) begin
        lat = k; done = o_done; err = o_err;
        break;
      end
    end
    i_req = 1'b0;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done || o_err || mem_req) extra++;
    end
    e = sb.pop_front();
    chk({e.tag, "_lat"},   32'(lat), 32'(e.lat));
    chk({e.tag, "_flags"}, {30'd0, done, err}, {30'd0, e.done, e.err});
    chk({e.tag, "_busy"},  {31'd0, busy1}, 32'd1);
    chk({e.tag, "_rdata"}, o_rdata, e.rdata);
    chk({e.tag, "_pos_type"}, {28'd0, o_pos, o_type}, {28'd0, e.pos, e.ty});
    chk({e.tag, "_nreq"},  32'(nreq), 32'(e.nreq));
    chk({e.tag, "_nwr"},   32'(wr_cnt - base), 32'(e.nwr));
    chk({e.tag, "_extra"}, 32'(extra), 32'd0);
    if (e.nreq > 0) chk({e.tag, "_addr"}, {21'd0, raddr}, {21'd0, e.addr});
    if (e.nwr > 0) begin
      chk({e.tag, "_waddr"}, {21'd0, last_wa}, {21'd0, e.addr});
      chk({e.tag, "_wdata"}, last_wd, e.wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   extra;
    logic seen;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {27'd0, o_busy, o_done, o_err, mem_req, mem_we}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_pos_type", {28'd0, o_pos, o_type}, 32'd0);
    chk("rst_mem", mem_wdata | {21'd0, mem_addr}, 32'd0);
    rst_n = 1'b1;

    ack_delay = 3; rd_word = 32'hDEAD_BEEF;
    push("ld_word", 5, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd0, WORD, 0, 11'd4, 32'd0, 4);
    run_access(1'b0, WORD, 32'h0000_0010, 32'd0);

    ack_delay = 0; rd_word = 32'h1122_3344;
    push("st_byte3", 4, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd3, BYTE, 1, 11'd8, 32'hAB22_3344, 2);
    run_access(1'b1, BYTE, 32'h0000_0023, 32'h0000_00AB);

    push("st_half2", 4, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd2, HALF, 1, 11'd0, 32'hCAFE_3344, 2);
    run_access(1'b1, HALF, 32'h0000_0002, 32'h0000_CAFE);

    push("st_word", 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd0, WORD, 1, 11'd5, 32'h1234_5678, 1);
    run_access(1'b1, WORD, 32'h0000_0014, 32'h1234_5678);

    rd_word = 32'hAABB_CCDD;
    push("st_byte0", 4, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd0, BYTE, 1, 11'd12, 32'hAABB_CC55, 2);
    run_access(1'b1, BYTE, 32'h0000_0030, 32'hFFFF_FF55);

    rd_word = 32'h5566_7788;
    push("st_half0", 4, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd0, HALF, 1, 11'd2, 32'h5566_1234, 2);
    run_access(1'b1, HALF, 32'h0000_0008, 32'hFFFF_1234);

    ack_delay = 1; rd_word = 32'h0BAD_F00D;
    push("ld_byte_top", 3, 1'b1, 1'b0, 32'h0BAD_F00D, 2'd3, BYTE, 0, 11'h1FF, 32'd0, 2);
    run_access(1'b0, BYTE, 32'h0000_07FF, 32'd0);

    no_ack = 1'b1; rd_word = 32'h9999_9999;
    push("ld_timeout", 5, 1'b0, 1'b1, 32'h0BAD_F00D, 2'd0, WORD, 0, 11'd16, 32'd0, 4);
    run_access(1'b0, WORD, 32'h0000_0040, 32'd0);
    no_ack = 1'b0; ack_delay = 0;

`ifdef MEM_ALIGN_CHK_EN
    push("st_half_mis", 1, 1'b0, 1'b1, 32'h0BAD_F00D, 2'd1, HALF, 0, 11'd0, 32'd0, 0);
    run_access(1'b1, HALF, 32'h0000_0001, 32'h0000_BEEF);
    push("st_word_mis", 1, 1'b0, 1'b1, 32'h0BAD_F00D, 2'd2, WORD, 0, 11'd0, 32'd0, 0);
    run_access(1'b1, WORD, 32'h0000_001E, 32'h0102_0304);
`else
    push("st_half_mis", 2, 1'b1, 1'b0, 32'h0BAD_F00D, 2'd1, HALF, 1, 11'd0, 32'h0000_BEEF, 1);
    run_access(1'b1, HALF, 32'h0000_0001, 32'h0000_BEEF);
    push("st_word_mis", 2, 1'b1, 1'b0, 32'h0BAD_F00D, 2'd2, WORD, 1, 11'd7, 32'h0102_0304, 1);
    run_access(1'b1, WORD, 32'h0000_001E, 32'h0102_0304);
`endif

    // Reset while a word write is waiting for its ack.
    no_ack = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b1; i_type = WORD; i_addr = 32'h0000_0020; i_wdata = 32'h0000_0077;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_wr_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {29'd0, mem_req, mem_we, o_busy}, 32'd0);
    chk("rst_async_rdata", o_rdata, 32'd0);
    i_req = 1'b0; no_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done || o_err || mem_req) extra++;
    end
    chk("rst_no_pulse", 32'(extra), 32'd0);

    rd_word = 32'hCAFE_F00D;
    push("ld_after_rst", 2, 1'b1, 1'b0, 32'hCAFE_F00D, 2'd0, WORD, 0, 11'd1, 32'd0, 1);
    run_access(1'b0, WORD, 32'h0000_0004, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
